// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the 8N1 UART receive path.
//   state_t   : receiver FSM state encoding (IDLE, START, DATA, STOP, BREAK)
//   DATA_BITS : payload bits per frame
//   bps_div() : clocks per bit from clock frequency and baud rate
//   maj3()    : 2-of-3 majority vote, used when UART_RX_MAJORITY_EN is defined
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  // Integer division, so the divisor truncates toward zero.
  function automatic int bps_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous serial line into the clk domain and flags falling
// edges on the synchronized copy. All flops reset to 1 (idle line level) so a
// reset never manufactures a start edge on its own.
//   clk      in  : system clock, rising edge
//   rst      in  : asynchronous active-high reset
//   rx_async in  : raw serial line
//   rx_s     out : line after the 2-flop synchronizer (2 clk latency)
//   rx_fall  out : rx_s was 1 on the previous clock and is 0 now
// -----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_async,
  output logic rx_s,
  output logic rx_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = rx_async;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbour and the chain
  // behaves as a true shift register regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rx_s    = sync_q;
  assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// 8N1 UART receiver: turns the RS-232 line into bytes for the character
// detector. Bits are sampled mid-bit using a clocks-per-bit counter that is
// re-aligned on every start-bit falling edge.
//
// Optional build macro UART_RX_MAJORITY_EN: each bit decision becomes the
// 2-of-3 majority of the synchronized line at sample point -1/0/+1 clock,
// taken at +1; every latency grows by one clock. Needs BPS_DIV >= 8.
//
// Parameters: CLK_FREQ (Hz), BAUD (bit/s); BPS_DIV = CLK_FREQ/BAUD >= 8.
// Ports:
//   Clk       in     : system clock, rising edge
//   Rst       in     : asynchronous active-high reset
//   Rs232_Rx  in     : serial line, idle high, asynchronous to Clk
//   data      out[8] : last correctly framed byte, LSB first on the line
//   rx_done   out    : one-cycle pulse, data updates on the same edge
//   frame_err out    : one-cycle pulse when the stop bit samples as 0
//   busy      out    : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rs232_Rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BPS_DIV = bps_div(CLK_FREQ, BAUD);
  localparam int CNT_W   = $clog2(BPS_DIV);

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_SLIP = 1;
`else
  localparam int SAMPLE_SLIP = 0;
`endif

  // Delaying the start-bit decision by the slip shifts the whole frame's bit
  // grid by the same amount, so data and stop decisions inherit it for free.
  localparam logic [CNT_W-1:0] START_PT = CNT_W'(BPS_DIV / 2 - 1 + SAMPLE_SLIP);
  localparam logic [CNT_W-1:0] BIT_PT   = CNT_W'(BPS_DIV - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_s;
  logic rx_fall;
  logic rx_bit;

  uart_rx_sync u_sync (
    .clk      (Clk),
    .rst      (Rst),
    .rx_async (Rs232_Rx),
    .rx_s     (rx_s),
    .rx_fall  (rx_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is rx_s one clock back, hist_q[1] two clocks back.
  logic [1:0] hist_q, hist_d;

  always_comb hist_d = {hist_q[0], rx_s};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) hist_q <= 2'b11;
    else     hist_q <= hist_d;
  end

  assign rx_bit = maj3(rx_s, hist_q[0], hist_q[1]);
`else
  assign rx_bit = rx_s;
`endif

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bps_cnt_q, bps_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   rx_done_q, rx_done_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;
  logic                   bit_tick;

  assign bit_tick = (bps_cnt_q == BIT_PT);

  // NOTE: every signal written here gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    bps_cnt_d   = bit_tick ? '0 : bps_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        bps_cnt_d = '0;
        if (rx_fall) state_d = START;
      end
      START: begin
        if (bps_cnt_q == START_PT) begin
          bps_cnt_d = '0;
          bit_cnt_d = '0;
          // A line already back high mid start bit was a glitch.
          state_d   = rx_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shreg_d[bit_cnt_q] = rx_bit;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (rx_bit) begin
            data_d    = shreg_q;
            rx_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        // Wait out a held-low line so it is not mistaken for a new start.
        bps_cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: the shift register and output byte are plain registers, not a
  // memory array, so they are reset together with the rest of the FSM.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      bps_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bps_cnt_q   <= bps_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign data      = data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Serial receive front end for the character-detection datapath (8N1 UART).
- Turns the asynchronous RS-232 line into 8-bit ASCII bytes.
- Downstream, the HELLO-detect stage consumes `data` and qualifies it with `rx_done`.
- Sits between the board pin and the sequence detector. Single clock domain, Clk.

Parameters:
- CLK_FREQ, 50_000_000: Clk frequency in Hz.
- BAUD, 9600: line bit rate in bit/s.
- BPS_DIV, CLK_FREQ/BAUD (integer divide): clocks per bit. Derived; must be ≥ 8.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset; asynchronous, active-high.
- Rs232_Rx  in  1  serial line, idle high; asynchronous to Clk.
- data  out  8  last correctly framed byte, LSB received first.
- rx_done  out  1  one-cycle pulse; `data` is updated on the same edge.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled as 0.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE; counters are 0. Synchronizer flops reset to 1 (line idle).
- Async Rst mid-frame aborts the frame immediately. After release, the FSM waits for a fresh falling edge; a partial frame never produces rx_done.
- Input conditioning:
  - 2-flop synchronizer, then a third flop for edge detect.
  - Falling edge = prev 1 and cur 0, on the synchronized signal.
  - Latency from pin to the synchronized signal: 2 Clk.
- bps_cnt counts 0..BPS_DIV-1 and wraps to 0. bit_cnt is 0..7.
- IDLE:
  - Falling edge → START, bps_cnt = 0.
  - busy asserts on the next cycle.
- START:
  - At bps_cnt == BPS_DIV/2 - 1 (mid start bit), sample the line.
  - Sample 0 → DATA, with bps_cnt = 0 and bit_cnt = 0.
  - Sample 1 → IDLE. This is a glitch reject: no pulse on any output.
- DATA:
  - Each time bps_cnt == BPS_DIV-1 (mid of the next bit), shift the sample into shreg[bit_cnt] and increment bit_cnt.
  - After the bit_cnt == 7 sample → STOP, bps_cnt = 0.
- STOP: at bps_cnt == BPS_DIV-1, sample the line.
  - Sample 1: data <= shreg, rx_done = 1 for exactly one cycle, → IDLE.
  - Sample 0: frame_err = 1 for one cycle; data keeps its old value; → BREAK.
- BREAK: stay until the synchronized line is 1, then → IDLE. No new start is accepted while the line is held low.
- rx_done and frame_err are mutually exclusive and never asserted in the same cycle.
- Back-to-back frames:
  - rx_done occurs mid stop bit, so the FSM is back in IDLE within half a bit.
  - The next start edge, arriving at least half a bit later, is caught with no gap requirement beyond standard 1 stop bit.
- Latency: rx_done rises 2 + BPS_DIV/2 + 9·BPS_DIV clocks (±1) after the start-bit falling edge at the pin.
- `data` holds its value between frames. It changes only on an rx_done cycle.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- When defined:
  - Every bit sample (start, data, stop) is the 2-of-3 majority of the synchronized line at sample point -1, 0 and +1 clocks.
  - The decision is taken at sample point +1, which adds 1 clock to all latencies.
  - Requires BPS_DIV ≥ 8.
- When undefined: single sample at the sample point, as described in Behaviour.

Decomposition:
- Shared package uart_pkg:
  - state typedef (IDLE, START, DATA, STOP, BREAK, 3 bits);
  - function bps_div(clk_freq, baud);
  - constant DATA_BITS = 8.
- One sub-module: uart_rx_sync. It contains the 2-FF synchronizer plus the previous-value flop, outputs rx_s and rx_fall, and resets to 1.

Test Plan (CLK_FREQ=50_000_000, BAUD=1_000_000 → BPS_DIV=50):
- Send "H" (0x48) with an ideal frame → one rx_done pulse, data=0x48, frame_err stays 0, busy drops within 25 clocks after the pulse.
- Send "H","E","L","L","O" back-to-back, 1 stop bit each → five rx_done pulses; data sequence 0x48, 0x45, 0x4C, 0x4C, 0x4F; rx_done spacing 500 clocks.
- 10-clock low glitch on an idle line → no rx_done, no frame_err; FSM back in IDLE by clock 30.
- Frame 0x41 with the stop bit forced to 0, line held low 200 clocks → frame_err pulse; data keeps its prior value; no start is accepted until the line goes high; the next 0x49 is received correctly.
- Assert Rst during bit 4 of 0x4F → outputs 0 immediately; no rx_done for that frame; a subsequent 0x48 is received correctly.
- UART_RX_MAJORITY_EN defined: inject a 1-clock inverted spike exactly at each data-bit sample point of 0x55 → data=0x55 with no error; rx_done arrives 1 clock later than in the undefined build.
